// File: rtl/axil_rd_responder.sv
// AXI4-Lite read responder: one AR at a time, 1-cycle-latency register bank read, registered R channel.
// Optional RREADY stall monitor built when AXIL_RD_WAIT_MON_EN is defined.
module axil_rd_responder #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS         = 16,
  parameter int unsigned MAXWAIT          = 5
) (
  input  logic                                                   AXI_ACLK,
  input  logic                                                   AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                            AXI_ARADDR,
  input  logic [2:0]                                             AXI_ARPROT,
  input  logic                                                   AXI_ARVALID,
  output logic                                                   AXI_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]                            AXI_RDATA,
  output logic [1:0]                                             AXI_RRESP,
  output logic                                                   AXI_RVALID,
  input  logic                                                   AXI_RREADY,
  output logic                                                   REG_RD_EN,
  output logic [C_AXI_ADDR_WIDTH-$clog2(C_AXI_DATA_WIDTH/8)-1:0] REG_RD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]                            REG_RD_DATA,
  output logic                                                   RD_WAIT_ERR
);

  localparam int unsigned ADDR_LSB = $clog2(C_AXI_DATA_WIDTH/8);
  localparam int unsigned IDX_W    = C_AXI_ADDR_WIDTH - ADDR_LSB;

  typedef enum logic [1:0] {IDLE, REQ, CAPT, RESP} state_t;

  state_t           state;
  logic             oor;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_oor;

  assign ar_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_oor = (32'(ar_idx) >= NUM_REGS);

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state       <= IDLE;
      oor         <= 1'b0;
      AXI_ARREADY <= 1'b0;
      AXI_RVALID  <= 1'b0;
      AXI_RDATA   <= '0;
      AXI_RRESP   <= 2'b00;
      REG_RD_EN   <= 1'b0;
      REG_RD_ADDR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (AXI_ARREADY && AXI_ARVALID) begin
            AXI_ARREADY <= 1'b0;
            oor         <= ar_oor;
            REG_RD_EN   <= !ar_oor;
            if (!ar_oor) REG_RD_ADDR <= ar_idx;
            state       <= REQ;
          end else begin
            AXI_ARREADY <= 1'b1;
          end
        end
        REQ: begin
          REG_RD_EN <= 1'b0;
          state     <= CAPT;
        end
        CAPT: begin
          // Out-of-range reads take the same path so latency is identical.
          AXI_RDATA  <= oor ? '0 : REG_RD_DATA;
          AXI_RRESP  <= oor ? 2'b10 : 2'b00;
          AXI_RVALID <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (AXI_RREADY) begin
            AXI_RVALID  <= 1'b0;
            AXI_ARREADY <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIL_RD_WAIT_MON_EN
  localparam int unsigned CW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

  logic [CW-1:0] stall_cnt;
  logic          unused_ok;

  assign unused_ok = ^{AXI_ARPROT, AXI_ARADDR[ADDR_LSB-1:0]};

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      stall_cnt   <= '0;
      RD_WAIT_ERR <= 1'b0;
    end else if (AXI_RVALID && AXI_RREADY) begin
      stall_cnt <= '0;
    end else if (AXI_RVALID && (stall_cnt != CW'(MAXWAIT))) begin
      stall_cnt <= stall_cnt + CW'(1);
      if (stall_cnt + CW'(1) == CW'(MAXWAIT)) RD_WAIT_ERR <= 1'b1;
    end
  end
`else
  logic unused_ok;

  assign unused_ok   = ^{AXI_ARPROT, AXI_ARADDR[ADDR_LSB-1:0], (MAXWAIT != 0)};
  assign RD_WAIT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_axil_rd_responder.sv
// Directed bench for axil_rd_responder: reset, in/out-of-range reads, backpressure, reset in RESP, wait monitor.
module tb_axil_rd_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
`ifdef AXIL_RD_WAIT_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          reg_rd_en;
  logic [5:0]    reg_rd_addr;
  logic [DW-1:0] reg_rd_data = 32'hBAD0_BAD0;
  logic          rd_wait_err;

  logic [DW-1:0] mem [64];
  int            en_cnt   = 0;
  int            beat_cnt = 0;
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  axil_rd_responder #(
    .C_AXI_DATA_WIDTH(DW),
    .C_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(16),
    .MAXWAIT(5)
  ) dut (
    .AXI_ACLK(clk),
    .AXI_ARESETN(rst_n),
    .AXI_ARADDR(araddr),
    .AXI_ARPROT(arprot),
    .AXI_ARVALID(arvalid),
    .AXI_ARREADY(arready),
    .AXI_RDATA(rdata),
    .AXI_RRESP(rresp),
    .AXI_RVALID(rvalid),
    .AXI_RREADY(rready),
    .REG_RD_EN(reg_rd_en),
    .REG_RD_ADDR(reg_rd_addr),
    .REG_RD_DATA(reg_rd_data),
    .RD_WAIT_ERR(rd_wait_err)
  );

  // Register bank with one-cycle read latency, plus strobe/beat counters.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rd_data <= mem[reg_rd_addr];
    if (reg_rd_en) en_cnt <= en_cnt + 1;
    if (rvalid && rready) beat_cnt <= beat_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int stall, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_resp, input bit exp_en, input logic [5:0] exp_idx);
    int en0;
    int beat0;
    en0     = en_cnt;
    beat0   = beat_cnt;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = (stall == 0);
    tick();
    arvalid = 1'b0;
    check("ar_accept_arready", arready, 0);
    check("rd_en_pulse", reg_rd_en, exp_en);
    if (exp_en) check("rd_addr", reg_rd_addr, exp_idx);
    tick();
    check("rd_en_single", reg_rd_en, 0);
    check("rvalid_not_early", rvalid, 0);
    tick();
    check("rvalid_rise", rvalid, 1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("hold_rvalid", rvalid, 1);
      check("hold_rdata", rdata, exp_data);
      check("hold_rresp", rresp, exp_resp);
      check("hold_arready", arready, 0);
    end
    rready = 1'b1;
    if (stall != 0) tick();
    else tick();
    check("rvalid_drop", rvalid, 0);
    check("arready_back", arready, 1);
    tick();
    check("rvalid_stays_low", rvalid, 0);
    check("beat_count", beat_cnt - beat0, 1);
    check("rd_en_count", en_cnt - en0, exp_en ? 1 : 0);
    check("rdata_kept", rdata, exp_data);
    rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    mem[3]  = 32'hDEAD_BEEF;
    mem[5]  = 32'h1234_5678;
    mem[15] = 32'hCAFE_F00D;

    rst_n   = 1'b0;
    arvalid = 1'b1;
    araddr  = 8'h0C;
    arprot  = 3'b010;
    rready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rd_en", reg_rd_en, 0);
    end
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rd_addr", reg_rd_addr, 0);
    check("rst_wait_err", rd_wait_err, 0);
    check("rst_no_strobe", en_cnt, 0);

    arvalid = 1'b0;
    rst_n   = 1'b1;
    #1;
    check("rel_rvalid", rvalid, 0);
    check("rel_arready_pre", arready, 0);
    tick();
    check("rel_arready", arready, 1);

    // basic, low bits ignored, top in-range index, out of range
    do_read(8'h0C, 0, 32'hDEAD_BEEF, 2'b00, 1'b1, 6'd3);
    do_read(8'h17, 0, 32'h1234_5678, 2'b00, 1'b1, 6'd5);
    do_read(8'h3C, 0, 32'hCAFE_F00D, 2'b00, 1'b1, 6'd15);
    do_read(8'h40, 0, 32'h0000_0000, 2'b10, 1'b0, 6'd0);

    // backpressure: 4 stall cycles stays under the wait limit
    do_read(8'h0C, 4, 32'hDEAD_BEEF, 2'b00, 1'b1, 6'd3);
    check("wait_err_under_limit", rd_wait_err, 0);
    do_read(8'hFC, 2, 32'h0000_0000, 2'b10, 1'b0, 6'd0);

    // reset while R beat pending
    araddr  = 8'h14;
    arvalid = 1'b1;
    rready  = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    tick();
    check("pre_rst_rvalid", rvalid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rvalid", rvalid, 0);
    check("async_arready", arready, 0);
    check("async_rdata", rdata, 0);
    begin
      int beat0;
      beat0  = beat_cnt;
      rready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_arready", arready, 1);
      tick();
      check("no_stale_beat", beat_cnt - beat0, 0);
      check("no_stale_rvalid", rvalid, 0);
      rready = 1'b0;
    end
    do_read(8'h14, 0, 32'h1234_5678, 2'b00, 1'b1, 6'd5);

    // wait monitor: 5 stall cycles hits the limit, flag is sticky
    do_read(8'h0C, 5, 32'hDEAD_BEEF, 2'b00, 1'b1, 6'd3);
    check("wait_err_set", rd_wait_err, MON);
    do_read(8'h3C, 0, 32'hCAFE_F00D, 2'b00, 1'b1, 6'd15);
    check("wait_err_sticky", rd_wait_err, MON);
    rst_n = 1'b0;
    #1;
    check("wait_err_cleared", rd_wait_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
